// File: rtl/latency_credit_fifo.sv
// -----------------------------------------------------------------------------
// latency_credit_fifo
//
// Output buffer that sits directly behind a fixed-latency, non-stallable
// compute pipeline. Each result is captured when the pipeline's delayed valid
// arrives. The result is then offered to a downstream ready/valid consumer in
// first-word-fall-through order.
//
// Upstream only gets a credit (issue_ready) while stored plus in-flight results
// stay below DEPTH. Because of this, a well-behaved upstream can never overrun
// the buffer, even though the pipeline itself cannot be stalled.
//
// Handshake: a word moves downstream in any cycle where out_valid && out_ready
// are both high at the rising edge. out_valid never drops and out_data never
// changes while out_valid is high and out_ready is low. On the input side
// there is no back-pressure: in_valid is a push that must be taken.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   issue_ready   upstream may start a pipeline operation this cycle
//   issue         upstream starts an operation this cycle
//   in_valid      delayed pipeline valid; in_data holds a result
//   in_data       pipeline result word
//   out_valid     buffer head is valid
//   out_data      buffer head word
//   out_ready     consumer accepts the head when out_valid is high
//   occupancy     number of stored entries
//   in_flight     issued operations whose results have not yet returned
//   err_overissue sticky: issue seen while issue_ready was low
//   err_overflow  sticky: in_valid dropped because the buffer was full
//   err_underflow sticky: in_valid seen while nothing was in flight
// -----------------------------------------------------------------------------
module latency_credit_fifo #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 16,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  issue_ready,
  input  logic                  issue,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      occupancy,
  output logic [CNT_W-1:0]      in_flight,
  output logic                  err_overissue,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic             err_overissue_q, err_overissue_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_underflow_q, err_underflow_d;

  logic             full;
  logic             pop;
  logic             push_acc;
  logic [CNT_W:0]   credit_sum;

  // The sum needs one extra bit: over-issue can push it past DEPTH.
  assign credit_sum  = {1'b0, occ_q} + {1'b0, infl_q};
  assign issue_ready = !rst && (credit_sum < (CNT_W+1)'(DEPTH));

  assign full      = (occ_q == CNT_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  // When the buffer is full, a push is taken only if the head leaves in the
  // same cycle. The write then lands in the slot being vacated.
  assign push_acc  = in_valid && (!full || pop);

  assign occupancy     = occ_q;
  assign in_flight     = infl_q;
  assign err_overissue = err_overissue_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    infl_d   = infl_q;

    // The pointers are PTR_W bits wide and DEPTH is a power of two,
    // so incrementing them wraps modulo DEPTH automatically.
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_acc, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    // A return with nothing in flight is flagged, and the counter saturates
    // at zero. Over-issue saturates at the top of the counter.
    case ({issue, in_valid})
      2'b10:   infl_d = (infl_q == '1) ? infl_q : infl_q + CNT_W'(1);
      2'b01:   infl_d = (infl_q == '0) ? infl_q : infl_q - CNT_W'(1);
      default: infl_d = infl_q;
    endcase

    err_overissue_d = err_overissue_q || (issue && !issue_ready);
    err_overflow_d  = err_overflow_q  || (in_valid && full && !pop);
    err_underflow_d = err_underflow_q || (in_valid && (infl_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      infl_q          <= '0;
      err_overissue_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      infl_q          <= infl_d;
      err_overissue_q <= err_overissue_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // The storage array has no reset. Entries are only read once they have
  // been written after reset.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
